usb_tx_framer: RTL
==================

# usb_tx_framer

Packetizing stage directly upstream of the FT2232H synchronous-FIFO write interface. Accepts signed samples from the FMCW processing chain, buffers them in an internal FIFO, and emits a byte stream (2-byte sync word, 8-bit frame counter, samples MSB-first) on `wdata_o`/`send_data_o`. Bytes advance only when the FT2232H reports space (`txe_n_i` low), so the downstream USB write stage needs no logic beyond byte transport.

## Interface
- `SAMPLE_WIDTH`, 16: input sample width, 9..16. Sign-extended to 16 bits before serialization.
- `FIFO_DEPTH`, 1024: sample FIFO entries. Power of two, at least 4.
- `SYNC0`, 8'hA5: first header byte.
- `SYNC1`, 8'h5A: second header byte.
- `clk_60mhz_i` input 1: FT2232H 60 MHz clock. All logic is on the rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `sample_i` input SAMPLE_WIDTH: signed sample.
- `sample_valid_i` input 1: sample present.
- `sample_last_i` input 1: qualifies the final sample of a chirp/frame.
- `sample_ready_o` output 1: FIFO can accept a sample.
- `txe_n_i` input 1: FT2232H TX-space flag, active-low.
- `wdata_o` output 8: byte offered to the USB write stage.
- `send_data_o` output 1: `wdata_o` is valid and must be sent.
- `frame_count_o` output 8: counter value to be used in the next header.
- `fifo_level_o` output log2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO storage:**
  - Each entry is {last, sext16(sample)}.
  - Push on a rising edge with `sample_valid_i && sample_ready_o`.
  - `sample_ready_o` = level < FIFO_DEPTH. It is derived from registered state only.
  - The head entry is held in a registered output slot (first-word fall-through). The head is valid whenever level > 0.
- **Byte consume rule:** a byte is consumed on a rising edge where `send_data_o && !txe_n_i`. When not consumed, `wdata_o` and the state hold unchanged.
- **State machine:**
  - `IDLE`: `send_data_o`=0. Goes to `HDR0` when level > 0.
  - `HDR0`: `wdata_o`=SYNC0, `send_data_o`=1. Goes to `HDR1` on consume.
  - `HDR1`: `wdata_o`=SYNC1, `send_data_o`=1. Goes to `CNT` on consume.
  - `CNT`: `wdata_o`=frame counter, `send_data_o`=1. Goes to `DHI` on consume.
  - `DHI`: `wdata_o`=head[15:8], `send_data_o`=(level > 0). Goes to `DLO` on consume.
  - `DLO`: `wdata_o`=head[7:0], `send_data_o`=1. On consume, pop the FIFO. If the popped entry has last=1, go to `IDLE` and increment the frame counter (mod 256). Otherwise go to `DHI`.
- **FIFO underrun:** an empty FIFO in `DHI` stalls the stream with `send_data_o`=0. No filler bytes are inserted. Frames never span a header.
- **Frame content:** each frame is exactly 3 + 2·N bytes, where N is the number of samples up to and including the one with last=1.
- **Outputs:** `wdata_o` and `send_data_o` are functions of registered state and the registered head only. There is no combinational path from `txe_n_i`.
- **`frame_count_o`:** equals the counter register.
- **Reset values:** `rst_i` forces all of the following, regardless of activity. Any partially sent frame is abandoned.
  - state `IDLE`
  - FIFO flushed, `fifo_level_o`=0
  - `sample_ready_o`=1
  - `send_data_o`=0, `wdata_o`=8'h00
  - `frame_count_o`=0

## Timing
- **Push to level:** a push at edge k makes level +1 visible after edge k.
- **First byte latency:** with the state in `IDLE`, `HDR0` is entered at edge k+1 and `send_data_o`=1 during cycle k+1..k+2. The first byte can be consumed at edge k+2.
- **Throughput:** with `txe_n_i` held low, one byte per clock, including across the header/data boundary and back-to-back frames. The only gap is one `IDLE` cycle between frames.
- **Push/pop in the same edge:** level is unchanged. A pop at full frees a slot, with `sample_ready_o`=1 on the next cycle. There is no push-through when full.
- **Stall:** when `txe_n_i` deasserts mid-frame, `wdata_o` is held. No byte is lost or duplicated. The USB stage's half-cycle `wr_n` registration relies on this hold.
- **Counter wrap:** 8'hFF is followed by 8'h00.

## Test plan
- **Single frame:** reset, push samples 16'h1234, 16'hABCD (last), `txe_n_i`=0 → bytes A5 5A 00 12 34 AB CD. `send_data_o` falls after CD, and `frame_count_o`=1.
- **Backpressure:** same stimulus, toggling `txe_n_i` pseudo-randomly → the identical byte sequence. `wdata_o` is stable across every edge with `txe_n_i`=1.
- **Fill and underrun:** push FIFO_DEPTH samples with `txe_n_i`=1 → `sample_ready_o`=0 and `fifo_level_o`=FIFO_DEPTH. Release `txe_n_i` and push slowly → `send_data_o` drops in `DHI` only, with no extra bytes.
- **Counter and sign extension:** 257 one-sample frames with SAMPLE_WIDTH=12 and sample 12'h800 → counter bytes 00..FF, 00. Data bytes are F8 00.
- **Reset mid-frame:** assert `rst_i` after the CNT byte → immediate `send_data_o`=0, level 0, counter 0. The next frame starts with A5 5A 00.

Source files
------------

// File: rtl/usb_tx_framer.sv
// Sample FIFO + byte packetizer feeding the FT2232H write stage: A5 5A cnt, then samples MSB-first.
// First byte offered one cycle after a sample lands; bytes advance only on send_data_o && !txe_n_i, otherwise held.
module usb_tx_framer #(
  parameter int          SAMPLE_WIDTH = 16,
  parameter int          FIFO_DEPTH   = 1024,
  parameter logic [7:0]  SYNC0        = 8'hA5,
  parameter logic [7:0]  SYNC1        = 8'h5A
) (
  input  logic                          clk_60mhz_i,
  input  logic                          rst_i,
  input  logic [SAMPLE_WIDTH-1:0]       sample_i,
  input  logic                          sample_valid_i,
  input  logic                          sample_last_i,
  output logic                          sample_ready_o,
  input  logic                          txe_n_i,
  output logic [7:0]                    wdata_o,
  output logic                          send_data_o,
  output logic [7:0]                    frame_count_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    CNT,
    DHI,
    DLO
  } state_t;

  state_t        state_q, state_d;
  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, mem_cnt_q;
  logic [16:0]   head_q;
  logic [7:0]    frame_cnt_q;
  logic [15:0]   sample_sext;
  logic [16:0]   push_entry;
  logic          head_vld, push, pop, head_take, mem_rd, mem_wr;

  assign sample_sext    = 16'($signed(sample_i));
  assign push_entry     = {sample_last_i, sample_sext};
  assign head_vld       = (level_q != '0);
  assign sample_ready_o = (level_q < DEPTH_L);
  assign push           = sample_valid_i && sample_ready_o;
  assign pop            = (state_q == DLO) && !txe_n_i;

  // The head slot refills from RAM when possible, else straight from the input.
  assign head_take = !head_vld || pop;
  assign mem_rd    = head_take && (mem_cnt_q != '0);
  assign mem_wr    = push && !(head_take && (mem_cnt_q == '0));

  always_ff @(posedge clk_60mhz_i) begin
    if (mem_wr) mem[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk_60mhz_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      level_q   <= '0;
      head_q    <= '0;
    end else begin
      if (mem_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (mem_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({mem_wr, mem_rd})
        2'b10:   mem_cnt_q <= mem_cnt_q + 1'b1;
        2'b01:   mem_cnt_q <= mem_cnt_q - 1'b1;
        default: mem_cnt_q <= mem_cnt_q;
      endcase
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (head_take) begin
        if (mem_cnt_q != '0) head_q <= mem[rd_ptr_q];
        else if (push)       head_q <= push_entry;
      end
    end
  end

  always_ff @(posedge clk_60mhz_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      frame_cnt_q <= 8'h00;
    end else begin
      state_q <= state_d;
      if (pop && head_q[16]) frame_cnt_q <= frame_cnt_q + 8'h01;
    end
  end

  always_comb begin
    state_d     = state_q;
    send_data_o = 1'b0;
    wdata_o     = 8'h00;
    case (state_q)
      IDLE: begin
        if (head_vld) state_d = HDR0;
      end
      HDR0: begin
        send_data_o = 1'b1;
        wdata_o     = SYNC0;
        if (!txe_n_i) state_d = HDR1;
      end
      HDR1: begin
        send_data_o = 1'b1;
        wdata_o     = SYNC1;
        if (!txe_n_i) state_d = CNT;
      end
      CNT: begin
        send_data_o = 1'b1;
        wdata_o     = frame_cnt_q;
        if (!txe_n_i) state_d = DHI;
      end
      // An empty FIFO here stalls the stream rather than padding it.
      DHI: begin
        send_data_o = head_vld;
        wdata_o     = head_q[15:8];
        if (head_vld && !txe_n_i) state_d = DLO;
      end
      DLO: begin
        send_data_o = 1'b1;
        wdata_o     = head_q[7:0];
        if (!txe_n_i) state_d = head_q[16] ? IDLE : DHI;
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_count_o = frame_cnt_q;
  assign fifo_level_o  = level_q;

endmodule
